// File: rtl/fc_outneuron_writer_pkg.sv
// Purpose: shared constants and types for the FC output-neuron write-back path.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package fc_outneuron_writer_pkg;

    // Layer geometry and number formats used as module parameter defaults
    localparam int FC_OUTNEURON_DEF       = 120;
    localparam int FC_PO_DEF              = 4;
    localparam int FC_ACCUM_WIDTH_DEF     = 32;
    localparam int FC_DATA_WIDTH_DEF      = 16;
    localparam int FC_OUTNEURON_ADDR_DEF  = 7;
    localparam int FC_FRAC_SHIFT_DEF      = 8;
    localparam int FC_RELU_EN_DEF         = 1;

    // Write-back sequencer states
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_DONE  = 2'd2
    } wr_state_t;

    // RAM word address of a given lane inside a given output group
    function automatic int neuron_addr(input int group, input int lane, input int po);
        return group * po + lane;
    endfunction

endpackage

// File: rtl/fc_quantize.sv
// Purpose: fixed-point requantizer: arithmetic shift, saturate to the stored width, optional ReLU.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows input.
module fc_quantize #(
    parameter int ACCUM_DATA_WIDTH_FC = 32,
    parameter int DATA_WIDTH_FC       = 16,
    parameter int FRAC_SHIFT          = 8,
    parameter int RELU_EN             = 1
) (
    input  logic [ACCUM_DATA_WIDTH_FC-1:0] acc,
    output logic [DATA_WIDTH_FC-1:0]       q
);

    localparam int AW = ACCUM_DATA_WIDTH_FC;
    localparam int DW = DATA_WIDTH_FC;

    // Representable range of the stored neuron, sign-extended to accumulator width
    localparam logic signed [AW-1:0] SAT_MAX = {{(AW-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [AW-1:0] SAT_MIN = {{(AW-DW+1){1'b1}}, {(DW-1){1'b0}}};

    logic signed [AW-1:0] shifted;

    // Floor-shift, clamp to the stored range, then drop negatives when ReLU is on
    always_comb begin
        shifted = $signed(acc) >>> FRAC_SHIFT;
        if (shifted > SAT_MAX) begin
            q = SAT_MAX[DW-1:0];
        end else if (shifted < SAT_MIN) begin
            q = SAT_MIN[DW-1:0];
        end else begin
            q = shifted[DW-1:0];
        end
        if ((RELU_EN != 0) && q[DW-1]) begin
            q = '0;
        end
    end

endmodule

// File: rtl/fc_outneuron_writer.sv
// Purpose: captures PO accumulator lanes per group, quantizes and serializes them into the output-neuron RAM.
// Latency: lane k of a group sampled at edge N is on the RAM port after edge N+1+k.
// Backpressure: none upstream; one group is buffered in a pending slot, a further group is dropped and flags overrun.
module fc_outneuron_writer
    import fc_outneuron_writer_pkg::*;
#(
    parameter int OUTNEURON               = FC_OUTNEURON_DEF,
    parameter int PO                      = FC_PO_DEF,
    parameter int ACCUM_DATA_WIDTH_FC     = FC_ACCUM_WIDTH_DEF,
    parameter int DATA_WIDTH_FC           = FC_DATA_WIDTH_DEF,
    parameter int FC_OUTNEURON_ADDR_WIDTH = FC_OUTNEURON_ADDR_DEF,
    parameter int FRAC_SHIFT              = FC_FRAC_SHIFT_DEF,
    parameter int RELU_EN                 = FC_RELU_EN_DEF
) (
    input  logic                                  clock,
    input  logic                                  reset,
    input  logic                                  enable,
    input  logic                                  accum_valid,
    input  logic [ACCUM_DATA_WIDTH_FC*PO-1:0]     accum_all,
    output logic                                  out_neuron_wren_a,
    output logic [FC_OUTNEURON_ADDR_WIDTH-1:0]    out_neuron_address_a,
    output logic [DATA_WIDTH_FC-1:0]              out_neuron_data_a,
    output logic                                  busy,
    output logic                                  overrun,
    output logic                                  done
);

    localparam int NGROUP = OUTNEURON / PO;
    localparam int LANE_W = (PO > 1) ? $clog2(PO) : 1;
    localparam int GRP_W  = (NGROUP > 1) ? $clog2(NGROUP + 1) : 1;
    localparam int AW     = ACCUM_DATA_WIDTH_FC;
    localparam int BUF_W  = AW * PO;

    localparam logic [LANE_W-1:0] LANE_LAST = LANE_W'(PO - 1);
    localparam logic [GRP_W-1:0]  GRP_LAST  = GRP_W'(NGROUP - 1);

    wr_state_t          state_q, state_d;
    logic [LANE_W-1:0]  lane_q, lane_d;
    logic [GRP_W-1:0]   group_q, group_d;
    logic [BUF_W-1:0]   act_q, act_d;
    logic [BUF_W-1:0]   pend_q, pend_d;
    logic               pend_full_q, pend_full_d;
    logic               overrun_d;
    logic               wren_d;
    logic               accum_go;
    logic [AW-1:0]      lane_acc;
    logic [DATA_WIDTH_FC-1:0]           lane_dat;
    logic [FC_OUTNEURON_ADDR_WIDTH-1:0] addr_d;

    assign accum_go = accum_valid && enable;
    assign lane_acc = act_q[int'(lane_q) * AW +: AW];
    assign addr_d   = FC_OUTNEURON_ADDR_WIDTH'(neuron_addr(int'(group_q), int'(lane_q), PO));

    fc_quantize #(
        .ACCUM_DATA_WIDTH_FC (ACCUM_DATA_WIDTH_FC),
        .DATA_WIDTH_FC       (DATA_WIDTH_FC),
        .FRAC_SHIFT          (FRAC_SHIFT),
        .RELU_EN             (RELU_EN)
    ) u_quantize (
        .acc (lane_acc),
        .q   (lane_dat)
    );

    // Next-state: capture groups, step lanes, chain pending groups back-to-back
    always_comb begin
        state_d     = state_q;
        lane_d      = lane_q;
        group_d     = group_q;
        act_d       = act_q;
        pend_d      = pend_q;
        pend_full_d = pend_full_q;
        overrun_d   = overrun;
        wren_d      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accum_go) begin
                    act_d   = accum_all;
                    lane_d  = '0;
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                wren_d = 1'b1;
                // A group arriving mid-burst parks in pending; a second one is lost
                if (accum_go) begin
                    if (!pend_full_q) begin
                        pend_d      = accum_all;
                        pend_full_d = 1'b1;
                    end else begin
                        overrun_d = 1'b1;
                    end
                end
                if (lane_q == LANE_LAST) begin
                    lane_d  = '0;
                    group_d = group_q + GRP_W'(1);
                    if (group_q == GRP_LAST) begin
                        state_d = S_DONE;
                    end else if (pend_full_d) begin
                        // Includes a group landing this very cycle, so no idle gap
                        act_d       = pend_d;
                        pend_full_d = 1'b0;
                        state_d     = S_WRITE;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    lane_d = lane_q + LANE_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_DONE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, buffers and registered RAM port / status outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q              <= S_IDLE;
            lane_q               <= '0;
            group_q              <= '0;
            act_q                <= '0;
            pend_q               <= '0;
            pend_full_q          <= 1'b0;
            out_neuron_wren_a    <= 1'b0;
            out_neuron_address_a <= '0;
            out_neuron_data_a    <= '0;
            busy                 <= 1'b0;
            overrun              <= 1'b0;
            done                 <= 1'b0;
        end else begin
            state_q              <= state_d;
            lane_q               <= lane_d;
            group_q              <= group_d;
            act_q                <= act_d;
            pend_q               <= pend_d;
            pend_full_q          <= pend_full_d;
            out_neuron_wren_a    <= wren_d;
            out_neuron_address_a <= wren_d ? addr_d : '0;
            out_neuron_data_a    <= wren_d ? lane_dat : '0;
            busy                 <= (state_d == S_WRITE) || pend_full_d;
            overrun              <= overrun_d;
            done                 <= (state_q == S_DONE);
        end
    end

endmodule
